dmem_arbiter: RTL and testbench

Shares the single-port synchronous data RAM between two requesters: port 0 is the RISC-V core data bus, and port 1 is a secondary master such as the program loader or a debug/DMA engine. The arbiter grants at most one access per cycle and drives the RAM. It routes the one-cycle-late read data back to the port that issued the read, and it bounds the wait time of port 1 so the loader cannot starve.

---
 rtl/dmem_arbiter.sv | 62 ++++++
 tb/tb_dmem_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the core (port 0) and a loader/DMA (port 1).
// Optional build macro DMEM_ARB_RR_EN selects round-robin conflict resolution instead of port-0 priority with starvation bound.
module dmem_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);
   logic       p1_prio;
   logic [1:0] rd_owner;
`ifdef DMEM_ARB_RR_EN
   logic last_winner;
   // conflict winner alternates; last_winner starts at port 1 so port 0 takes the first conflict
   always_ff @(posedge CLK)
      if (RESET) last_winner <= 1'b1;
      else if (m0_req && m1_req) last_winner <= m1_gnt;
   assign p1_prio = !last_winner;
`else
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   logic [3:0] starve_cnt;
   // counts consecutive denied port 1 cycles, saturating at the starvation bound
   always_ff @(posedge CLK)
      if (RESET || !m1_req || m1_gnt) starve_cnt <= '0;
      else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
   assign p1_prio = starve_cnt == SMAX;
`endif
   // grant and RAM mux; no grant at all while reset is held
   always_comb begin
      m1_gnt    = !RESET && m1_req && (!m0_req || p1_prio);
      m0_gnt    = !RESET && m0_req && !m1_gnt;
      mem_addr  = m1_gnt ? m1_addr : m0_addr;
      mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
      mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
   end
   // remember which port owns the read data arriving next cycle
   always_ff @(posedge CLK)
      rd_owner <= RESET ? 2'b00 : {m1_gnt && !m1_we, m0_gnt && !m0_we};
   assign m0_rvalid = rd_owner[0];
   assign m1_rvalid = rd_owner[1];
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter with a behavioural RAM and arbitration model.
module tb_dmem_arbiter;
   localparam int SM = 4;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [9:0]  m0_addr, m1_addr, mem_addr;
   logic [31:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata, m0_rdata, m1_rdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
   dmem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(SM)) dut (
      .CLK(CLK), .RESET(RESET),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );
   always #5 CLK = ~CLK;
   logic [31:0] ram [1024];
   initial for (int i = 0; i < 1024; i++) ram[i] = '0;
   always @(posedge CLK) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end
   typedef struct {int port; int due; logic [31:0] data;} rd_t;
   rd_t         q[$];
   logic [31:0] mm [1024];
   int          tests = 0, fails = 0, cyc = 0, waited = 0;
   logic        lastw = 1'b1, e0, e1;
   initial for (int i = 0; i < 1024; i++) mm[i] = '0;
   task automatic step(input logic rst, input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1);
      logic        ewe;
      logic [9:0]  ea;
      logic [31:0] ed;
      RESET = rst; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      @(negedge CLK);
      if (rst) begin
         e0 = 0; e1 = 0;
      end else begin
`ifdef DMEM_ARB_RR_EN
         e1 = r1 && (!r0 || !lastw);
`else
         e1 = r1 && (!r0 || waited >= SM);
`endif
         e0 = r0 && !e1;
      end
      ewe = (e0 && w0) || (e1 && w1);
      ea  = e1 ? a1 : a0;
      ed  = e1 ? d1 : d0;
      tests++;
      if ({m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata} !== {e0, e1, ewe, ea, ed}) begin
         fails++;
         $display("FAIL grant cyc=%0d got gnt=%b%b we=%b addr=%h wd=%h need gnt=%b%b we=%b addr=%h wd=%h",
                  cyc, m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata, e0, e1, ewe, ea, ed);
      end
      if ((e0 && !w0) || (e1 && !w1)) q.push_back('{e1 ? 1 : 0, cyc + 1, mm[ea]});
      if (ewe) mm[ea] = ed;
      if (rst) begin
         waited = 0; lastw = 1'b1;
      end else begin
         waited = (r1 && !e1) ? waited + 1 : 0;
         if (r0 && r1) lastw = e1;
      end
      @(posedge CLK);
      #1 cyc++;
   endtask
   initial begin : monitor
      rd_t         e;
      logic        x0, x1;
      logic [31:0] xd;
      forever begin
         @(posedge CLK);
         #2;
         if (cyc > 0) begin
            x0 = 0; x1 = 0; xd = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
               e = q.pop_front();
               x0 = e.port == 0; x1 = e.port == 1; xd = e.data;
            end
            tests++;
            if ({m0_rvalid, m1_rvalid} !== {x0, x1}) begin
               fails++;
               $display("FAIL rvalid cyc=%0d got %b%b need %b%b", cyc, m0_rvalid, m1_rvalid, x0, x1);
            end else if (x0 || x1) begin
               tests++;
               if ((x0 ? m0_rdata : m1_rdata) !== xd) begin
                  fails++;
                  $display("FAIL rdata cyc=%0d port=%0d got %h need %h", cyc, x1, x0 ? m0_rdata : m1_rdata, xd);
               end
            end
         end
      end
   end
   initial begin : stim
      logic        rs, r0, w0, r1, w1, h0, h1;
      logic [9:0]  a0, a1;
      logic [31:0] d0, d1;
      int          p;
      RESET = 1; m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      @(posedge CLK);
      #1;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 10'h3, 32'h5, 1, 1, 10'h4, 32'h6);
      step(0, 1, 1, 10'h010, 32'hDEADBEEF, 0, 0, 0, 0);
      step(0, 1, 0, 10'h010, 0, 0, 0, 0, 0);
      step(0, 1, 1, 10'h001, 32'h11, 0, 0, 0, 0);
      step(0, 1, 1, 10'h002, 32'h22, 0, 0, 0, 0);
      step(0, 1, 0, 10'h001, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 10'h002, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 10'h155, 32'hCAFE0001);
      step(0, 1, 0, 10'h155, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 10'(i), 0, 1, 0, 10'(i + 1), 0);
      step(0, 1, 0, 10'h010, 0, 0, 0, 0, 0);
      step(1, 1, 0, 10'h010, 0, 1, 0, 10'h001, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      h0 = 0; h1 = 0; r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (int i = 0; i < 3000; i++) begin
         p = ((i / 500) % 2) ? 95 : 50;
         if (!h0) begin
            r0 = $urandom_range(0, 99) < p; w0 = 1'($urandom_range(0, 1));
            a0 = 10'($urandom_range(0, 15)); d0 = $urandom;
         end
         if (!h1) begin
            r1 = $urandom_range(0, 99) < p; w1 = 1'($urandom_range(0, 1));
            a1 = 10'($urandom_range(0, 15)); d1 = $urandom;
         end
         rs = $urandom_range(0, 199) == 0;
         step(rs, r0, w0, a0, d0, r1, w1, a1, d1);
         h0 = r0 && !e0;
         h1 = r1 && !e1;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending reads need 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
